rv32i_decode_execute: RTL and testbench

- Decode-through-execute slice of the 5-stage RV32I pipeline.
- Combinationally decodes the ID-stage instruction and holds the ID/EX pipeline register.
- Forwards operands from the MEM and WB stages and computes the ALU result, branch/jump target and store data for the EX/MEM register.
- Sits between the IF/ID register plus register file (upstream) and the EX/MEM register (downstream).

---
 rtl/rv32i_decode_execute_if.sv | 27 ++
 rtl/rv32i_decode_execute.sv | 273 +++++++++++++++++++++++++++
 tb/tb_rv32i_decode_execute.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/rv32i_decode_execute_if.sv
// EX-stage output bus of the decode/execute slice: the ID/EX register contents
// plus the forwarded ALU result, store data and branch target feeding EX/MEM.
interface rv32i_decode_execute_if;
    logic [31:0] ex_pc;
    logic [4:0]  ex_rd_addr;
    logic        ex_jal;
    logic        ex_jalr;
    logic        ex_branch;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic        ex_reg_write;
    logic [31:0] ex_result;
    logic [31:0] ex_store_data;
    logic [31:0] ex_branch_addr;

    modport master (
        output ex_pc, ex_rd_addr, ex_jal, ex_jalr, ex_branch,
               ex_mem_read, ex_mem_write, ex_reg_write,
               ex_result, ex_store_data, ex_branch_addr
    );

    modport slave (
        input  ex_pc, ex_rd_addr, ex_jal, ex_jalr, ex_branch,
               ex_mem_read, ex_mem_write, ex_reg_write,
               ex_result, ex_store_data, ex_branch_addr
    );
endinterface

// File: rtl/rv32i_decode_execute.sv
// RV32I decode + ID/EX register + EX stage: operand forwarding from MEM/WB,
// load-use stall detection, ALU, and branch/jump target generation.
module rv32i_decode_execute #(
    parameter int XLEN = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [31:0]     id_instr,
    input  logic [XLEN-1:0] id_pc,
    input  logic [XLEN-1:0] id_rs1_val,
    input  logic [XLEN-1:0] id_rs2_val,
    input  logic            flush,
    input  logic            mem_reg_write,
    input  logic [4:0]      mem_rd_addr,
    input  logic [XLEN-1:0] mem_rd_val,
    input  logic [4:0]      wb_rd_addr,
    input  logic [XLEN-1:0] wb_rd_val,
    output logic [4:0]      id_rs1_addr,
    output logic [4:0]      id_rs2_addr,
    output logic            id_jal,
    output logic [XLEN-1:0] id_imm,
    output logic            stall,
    rv32i_decode_execute_if.master ex_bus
);

    localparam logic [3:0] ALU_NONE = 4'd0;
    localparam logic [3:0] ALU_ADD  = 4'd1;
    localparam logic [3:0] ALU_SUB  = 4'd2;
    localparam logic [3:0] ALU_AND  = 4'd3;
    localparam logic [3:0] ALU_OR   = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SLL  = 4'd6;
    localparam logic [3:0] ALU_SRL  = 4'd7;
    localparam logic [3:0] ALU_SRA  = 4'd8;
    localparam logic [3:0] ALU_SLT  = 4'd9;
    localparam logic [3:0] ALU_SLTU = 4'd10;
    localparam logic [3:0] ALU_EQ   = 4'd11;
    localparam logic [3:0] ALU_NE   = 4'd12;
    localparam logic [3:0] ALU_GE   = 4'd13;
    localparam logic [3:0] ALU_GEU  = 4'd14;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_alt;

    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_shamt;

    logic            d_jal, d_jalr, d_branch, d_lui, d_auipc;
    logic            d_mem_read, d_mem_write, d_alu_src, d_reg_write;
    logic [3:0]      d_alu_op;
    logic [XLEN-1:0] d_imm;

    logic [XLEN-1:0] ex_pc_q, ex_rs1_val_q, ex_rs2_val_q, ex_imm_q;
    logic [4:0]      ex_rs1_addr_q, ex_rs2_addr_q, ex_rd_addr_q;
    logic            ex_jal_q, ex_jalr_q, ex_branch_q, ex_lui_q, ex_auipc_q;
    logic            ex_mem_read_q, ex_mem_write_q, ex_alu_src_q, ex_reg_write_q;
    logic [3:0]      ex_alu_op_q;

    logic [XLEN-1:0] fwd_rs1, fwd_rs2, alu_src1, alu_src2, alu_out;
    logic            bubble;

    assign opcode      = id_instr[6:0];
    assign funct3      = id_instr[14:12];
    assign funct7_alt  = id_instr[30];
    assign id_rs1_addr = id_instr[19:15];
    assign id_rs2_addr = id_instr[24:20];

    assign imm_i     = {{20{id_instr[31]}}, id_instr[31:20]};
    assign imm_s     = {{20{id_instr[31]}}, id_instr[31:25], id_instr[11:7]};
    assign imm_b     = {{19{id_instr[31]}}, id_instr[31], id_instr[7],
                        id_instr[30:25], id_instr[11:8], 1'b0};
    assign imm_u     = {id_instr[31:12], 12'b0};
    assign imm_j     = {{11{id_instr[31]}}, id_instr[31], id_instr[19:12],
                        id_instr[20], id_instr[30:21], 1'b0};
    assign imm_shamt = {{(XLEN-5){1'b0}}, id_instr[24:20]};

    always_comb begin
        d_jal       = 1'b0;
        d_jalr      = 1'b0;
        d_branch    = 1'b0;
        d_lui       = 1'b0;
        d_auipc     = 1'b0;
        d_mem_read  = 1'b0;
        d_mem_write = 1'b0;
        d_alu_src   = 1'b0;
        d_reg_write = 1'b0;
        d_alu_op    = ALU_NONE;
        d_imm       = '0;
        case (opcode)
            OPC_LUI: begin
                d_lui = 1'b1; d_alu_op = ALU_ADD; d_alu_src = 1'b1;
                d_reg_write = 1'b1; d_imm = imm_u;
            end
            OPC_AUIPC: begin
                d_auipc = 1'b1; d_alu_op = ALU_ADD; d_alu_src = 1'b1;
                d_reg_write = 1'b1; d_imm = imm_u;
            end
            OPC_JAL: begin
                d_jal = 1'b1; d_reg_write = 1'b1; d_imm = imm_j;
            end
            OPC_JALR: begin
                d_jalr = 1'b1; d_alu_op = ALU_ADD; d_alu_src = 1'b1;
                d_reg_write = 1'b1; d_imm = imm_i;
            end
            OPC_BRANCH: begin
                d_branch = 1'b1; d_imm = imm_b;
                case (funct3)
                    3'b000:  d_alu_op = ALU_EQ;
                    3'b001:  d_alu_op = ALU_NE;
                    3'b100:  d_alu_op = ALU_SLT;
                    3'b101:  d_alu_op = ALU_GE;
                    3'b110:  d_alu_op = ALU_SLTU;
                    3'b111:  d_alu_op = ALU_GEU;
                    default: d_alu_op = ALU_NONE;
                endcase
            end
            OPC_LOAD: begin
                d_mem_read = 1'b1; d_alu_op = ALU_ADD; d_alu_src = 1'b1;
                d_reg_write = 1'b1; d_imm = imm_i;
            end
            OPC_STORE: begin
                d_mem_write = 1'b1; d_alu_op = ALU_ADD; d_alu_src = 1'b1;
                d_imm = imm_s;
            end
            OPC_OPIMM: begin
                d_alu_src = 1'b1; d_reg_write = 1'b1; d_imm = imm_i;
                case (funct3)
                    3'b000: d_alu_op = ALU_ADD;
                    3'b010: d_alu_op = ALU_SLT;
                    3'b011: d_alu_op = ALU_SLTU;
                    3'b100: d_alu_op = ALU_XOR;
                    3'b110: d_alu_op = ALU_OR;
                    3'b111: d_alu_op = ALU_AND;
                    3'b001: begin
                        d_alu_op = ALU_SLL; d_imm = imm_shamt;
                    end
                    default: begin
                        d_alu_op = funct7_alt ? ALU_SRA : ALU_SRL;
                        d_imm    = imm_shamt;
                    end
                endcase
            end
            OPC_OP: begin
                d_reg_write = 1'b1;
                case (funct3)
                    3'b000:  d_alu_op = funct7_alt ? ALU_SUB : ALU_ADD;
                    3'b001:  d_alu_op = ALU_SLL;
                    3'b010:  d_alu_op = ALU_SLT;
                    3'b011:  d_alu_op = ALU_SLTU;
                    3'b100:  d_alu_op = ALU_XOR;
                    3'b101:  d_alu_op = funct7_alt ? ALU_SRA : ALU_SRL;
                    3'b110:  d_alu_op = ALU_OR;
                    default: d_alu_op = ALU_AND;
                endcase
            end
            default: begin
                d_alu_op = ALU_NONE;
            end
        endcase
    end

    assign id_jal = d_jal;
    assign id_imm = d_imm;

    // Load-use: the loaded value is not available for forwarding until MEM completes.
    assign stall  = ex_mem_read_q && (ex_rd_addr_q != 5'd0) &&
                    ((id_rs1_addr == ex_rd_addr_q) || (id_rs2_addr == ex_rd_addr_q));
    assign bubble = flush || stall;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ex_pc_q        <= '0;
            ex_rs1_addr_q  <= '0;
            ex_rs2_addr_q  <= '0;
            ex_rs1_val_q   <= '0;
            ex_rs2_val_q   <= '0;
            ex_rd_addr_q   <= '0;
            ex_imm_q       <= '0;
            ex_jal_q       <= 1'b0;
            ex_jalr_q      <= 1'b0;
            ex_branch_q    <= 1'b0;
            ex_lui_q       <= 1'b0;
            ex_auipc_q     <= 1'b0;
            ex_mem_read_q  <= 1'b0;
            ex_mem_write_q <= 1'b0;
            ex_alu_src_q   <= 1'b0;
            ex_reg_write_q <= 1'b0;
            ex_alu_op_q    <= ALU_NONE;
        end else begin
            ex_pc_q        <= id_pc;
            ex_rs1_addr_q  <= id_rs1_addr;
            ex_rs2_addr_q  <= id_rs2_addr;
            ex_rs1_val_q   <= id_rs1_val;
            ex_rs2_val_q   <= id_rs2_val;
            ex_rd_addr_q   <= id_instr[11:7];
            ex_imm_q       <= d_imm;
            ex_jal_q       <= bubble ? 1'b0 : d_jal;
            ex_jalr_q      <= bubble ? 1'b0 : d_jalr;
            ex_branch_q    <= bubble ? 1'b0 : d_branch;
            ex_lui_q       <= bubble ? 1'b0 : d_lui;
            ex_auipc_q     <= bubble ? 1'b0 : d_auipc;
            ex_mem_read_q  <= bubble ? 1'b0 : d_mem_read;
            ex_mem_write_q <= bubble ? 1'b0 : d_mem_write;
            ex_alu_src_q   <= bubble ? 1'b0 : d_alu_src;
            ex_reg_write_q <= bubble ? 1'b0 : d_reg_write;
            ex_alu_op_q    <= bubble ? ALU_NONE : d_alu_op;
        end
    end

    // MEM result is younger than WB, so it wins when both target the same register.
    always_comb begin
        fwd_rs1 = ex_rs1_val_q;
        if (mem_reg_write && (mem_rd_addr != 5'd0) && (mem_rd_addr == ex_rs1_addr_q))
            fwd_rs1 = mem_rd_val;
        else if ((wb_rd_addr != 5'd0) && (wb_rd_addr == ex_rs1_addr_q))
            fwd_rs1 = wb_rd_val;
    end

    always_comb begin
        fwd_rs2 = ex_rs2_val_q;
        if (mem_reg_write && (mem_rd_addr != 5'd0) && (mem_rd_addr == ex_rs2_addr_q))
            fwd_rs2 = mem_rd_val;
        else if ((wb_rd_addr != 5'd0) && (wb_rd_addr == ex_rs2_addr_q))
            fwd_rs2 = wb_rd_val;
    end

    assign alu_src1 = ex_lui_q ? '0 : (ex_auipc_q ? ex_pc_q : fwd_rs1);
    assign alu_src2 = ex_alu_src_q ? ex_imm_q : fwd_rs2;

    always_comb begin
        alu_out = '0;
        case (ex_alu_op_q)
            ALU_ADD:  alu_out = alu_src1 + alu_src2;
            ALU_SUB:  alu_out = alu_src1 - alu_src2;
            ALU_AND:  alu_out = alu_src1 & alu_src2;
            ALU_OR:   alu_out = alu_src1 | alu_src2;
            ALU_XOR:  alu_out = alu_src1 ^ alu_src2;
            ALU_SLL:  alu_out = alu_src1 << alu_src2[4:0];
            ALU_SRL:  alu_out = alu_src1 >> alu_src2[4:0];
            ALU_SRA:  alu_out = $unsigned($signed(alu_src1) >>> alu_src2[4:0]);
            ALU_SLT:  alu_out = {{(XLEN-1){1'b0}}, $signed(alu_src1) < $signed(alu_src2)};
            ALU_SLTU: alu_out = {{(XLEN-1){1'b0}}, alu_src1 < alu_src2};
            ALU_EQ:   alu_out = {{(XLEN-1){1'b0}}, alu_src1 == alu_src2};
            ALU_NE:   alu_out = {{(XLEN-1){1'b0}}, alu_src1 != alu_src2};
            ALU_GE:   alu_out = {{(XLEN-1){1'b0}}, $signed(alu_src1) >= $signed(alu_src2)};
            ALU_GEU:  alu_out = {{(XLEN-1){1'b0}}, alu_src1 >= alu_src2};
            default:  alu_out = '0;
        endcase
    end

    assign ex_bus.ex_pc          = ex_pc_q;
    assign ex_bus.ex_rd_addr     = ex_rd_addr_q;
    assign ex_bus.ex_jal         = ex_jal_q;
    assign ex_bus.ex_jalr        = ex_jalr_q;
    assign ex_bus.ex_branch      = ex_branch_q;
    assign ex_bus.ex_mem_read    = ex_mem_read_q;
    assign ex_bus.ex_mem_write   = ex_mem_write_q;
    assign ex_bus.ex_reg_write   = ex_reg_write_q;
    assign ex_bus.ex_result      = alu_out;
    assign ex_bus.ex_store_data  = fwd_rs2;
    assign ex_bus.ex_branch_addr = ex_jalr_q ? alu_out : (ex_pc_q + ex_imm_q);

endmodule

// File: tb/tb_rv32i_decode_execute.sv
// Directed-vector bench for rv32i_decode_execute with hand-computed expectations.
module tb_rv32i_decode_execute;

    logic        clock;
    logic        reset;
    logic [31:0] id_instr, id_pc, id_rs1_val, id_rs2_val;
    logic        flush;
    logic        mem_reg_write;
    logic [4:0]  mem_rd_addr, wb_rd_addr;
    logic [31:0] mem_rd_val, wb_rd_val;
    logic [4:0]  id_rs1_addr, id_rs2_addr;
    logic        id_jal;
    logic [31:0] id_imm;
    logic        stall;

    int vector_count;
    int miscompare_count;

    rv32i_decode_execute_if ex_bus ();

    rv32i_decode_execute #(.XLEN(32)) dut (
        .clock         (clock),
        .reset         (reset),
        .id_instr      (id_instr),
        .id_pc         (id_pc),
        .id_rs1_val    (id_rs1_val),
        .id_rs2_val    (id_rs2_val),
        .flush         (flush),
        .mem_reg_write (mem_reg_write),
        .mem_rd_addr   (mem_rd_addr),
        .mem_rd_val    (mem_rd_val),
        .wb_rd_addr    (wb_rd_addr),
        .wb_rd_val     (wb_rd_val),
        .id_rs1_addr   (id_rs1_addr),
        .id_rs2_addr   (id_rs2_addr),
        .id_jal        (id_jal),
        .id_imm        (id_imm),
        .stall         (stall),
        .ex_bus        (ex_bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vector_count++;
        if (got !== exp) begin
            miscompare_count++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Present one instruction in ID and let it cross into EX.
    task automatic applyStimulus(input logic [31:0] instr, input logic [31:0] pc,
                                 input logic [31:0] rs1v, input logic [31:0] rs2v);
        id_instr   = instr;
        id_pc      = pc;
        id_rs1_val = rs1v;
        id_rs2_val = rs2v;
        @(posedge clock);
        #1;
    endtask

    task automatic clearForwarding();
        mem_reg_write = 1'b0;
        mem_rd_addr   = 5'd0;
        mem_rd_val    = 32'd0;
        wb_rd_addr    = 5'd0;
        wb_rd_val     = 32'd0;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vector_count     = 0;
        miscompare_count = 0;
        reset      = 1'b1;
        flush      = 1'b0;
        id_instr   = 32'd0;
        id_pc      = 32'd0;
        id_rs1_val = 32'd0;
        id_rs2_val = 32'd0;
        clearForwarding();

        repeat (2) @(posedge clock);
        #1;
        checkOutput("rst_reg_write", {31'd0, ex_bus.ex_reg_write}, 32'd0);
        checkOutput("rst_mem_read",  {31'd0, ex_bus.ex_mem_read},  32'd0);
        checkOutput("rst_branch",    {31'd0, ex_bus.ex_branch},    32'd0);
        checkOutput("rst_jal",       {31'd0, ex_bus.ex_jal},       32'd0);
        checkOutput("rst_result",    ex_bus.ex_result,             32'd0);
        checkOutput("rst_pc",        ex_bus.ex_pc,                 32'd0);
        checkOutput("rst_stall",     {31'd0, stall},               32'd0);
        reset = 1'b0;

        // addi x1,x0,5
        applyStimulus(32'h00500093, 32'h0, 32'd0, 32'd0);
        checkOutput("addi_result",    ex_bus.ex_result,                32'd5);
        checkOutput("addi_reg_write", {31'd0, ex_bus.ex_reg_write},    32'd1);
        checkOutput("addi_rd",        {27'd0, ex_bus.ex_rd_addr},      32'd1);

        // sub x3,x1,x2 : 3 - 5
        applyStimulus(32'h402081B3, 32'h4, 32'd3, 32'd5);
        checkOutput("sub_result", ex_bus.ex_result, 32'hFFFFFFFE);

        // add x3,x1,x2 with forwarding scenarios applied while in EX
        applyStimulus(32'h002081B3, 32'h8, 32'd0, 32'd0);
        mem_reg_write = 1'b1; mem_rd_addr = 5'd1; mem_rd_val = 32'd10;
        wb_rd_addr = 5'd2; wb_rd_val = 32'd7;
        #1;
        checkOutput("fwd_mem_wb_result", ex_bus.ex_result,     32'd17);
        checkOutput("fwd_store_data",    ex_bus.ex_store_data, 32'd7);
        wb_rd_addr = 5'd1; wb_rd_val = 32'd99;
        #1;
        checkOutput("fwd_mem_priority", ex_bus.ex_result, 32'd10);
        mem_rd_addr = 5'd0;
        #1;
        checkOutput("fwd_x0_ignored", ex_bus.ex_result, 32'd99);
        mem_reg_write = 1'b0; mem_rd_addr = 5'd1; wb_rd_addr = 5'd0;
        #1;
        checkOutput("fwd_mem_no_write", ex_bus.ex_result, 32'd0);
        clearForwarding();

        // lw x5,0(x1) then dependent add x3,x5,x2
        applyStimulus(32'h0000A283, 32'hC, 32'h100, 32'd0);
        checkOutput("lw_mem_read", {31'd0, ex_bus.ex_mem_read}, 32'd1);
        checkOutput("lw_addr",     ex_bus.ex_result,            32'h100);
        checkOutput("lw_rd",       {27'd0, ex_bus.ex_rd_addr},  32'd5);
        id_instr = 32'h002081B3;
        #1;
        checkOutput("nodep_stall", {31'd0, stall}, 32'd0);
        id_instr = 32'h002281B3;
        #1;
        checkOutput("loaduse_stall", {31'd0, stall}, 32'd1);
        @(posedge clock);
        #1;
        checkOutput("bubble_reg_write", {31'd0, ex_bus.ex_reg_write}, 32'd0);
        checkOutput("bubble_mem_read",  {31'd0, ex_bus.ex_mem_read},  32'd0);
        checkOutput("bubble_result",    ex_bus.ex_result,             32'd0);
        checkOutput("bubble_stall_clr", {31'd0, stall},               32'd0);

        // beq x1,x2,+8 at pc 0x40
        applyStimulus(32'h00208463, 32'h40, 32'd7, 32'd7);
        checkOutput("beq_taken",  ex_bus.ex_result,             32'd1);
        checkOutput("beq_branch", {31'd0, ex_bus.ex_branch},    32'd1);
        checkOutput("beq_target", ex_bus.ex_branch_addr,        32'h48);
        applyStimulus(32'h00208463, 32'h40, 32'd7, 32'd8);
        checkOutput("beq_not_taken", ex_bus.ex_result, 32'd0);
        flush = 1'b1;
        applyStimulus(32'h00208463, 32'h40, 32'd7, 32'd7);
        checkOutput("flush_branch", {31'd0, ex_bus.ex_branch}, 32'd0);
        checkOutput("flush_result", ex_bus.ex_result,          32'd0);
        flush = 1'b0;

        // jal x1,+16
        id_instr = 32'h010000EF;
        #1;
        checkOutput("id_jal", {31'd0, id_jal}, 32'd1);
        checkOutput("id_imm", id_imm,          32'd16);
        applyStimulus(32'h010000EF, 32'h80, 32'd0, 32'd0);
        checkOutput("jal_ex",     {31'd0, ex_bus.ex_jal},       32'd1);
        checkOutput("jal_rw",     {31'd0, ex_bus.ex_reg_write}, 32'd1);
        checkOutput("jal_target", ex_bus.ex_branch_addr,        32'h90);

        // lui x1,0x12345 ignores rs1 data
        applyStimulus(32'h123450B7, 32'h0, 32'h0000FFFF, 32'd0);
        checkOutput("lui_result", ex_bus.ex_result, 32'h12345000);

        // auipc x2,0x1 at pc 0x100
        applyStimulus(32'h00001117, 32'h100, 32'd0, 32'd0);
        checkOutput("auipc_result", ex_bus.ex_result, 32'h1100);

        // jalr x0,4(x1)
        applyStimulus(32'h00408067, 32'h20, 32'h200, 32'd0);
        checkOutput("jalr_result", ex_bus.ex_result,         32'h204);
        checkOutput("jalr_target", ex_bus.ex_branch_addr,    32'h204);
        checkOutput("jalr_flag",   {31'd0, ex_bus.ex_jalr},  32'd1);

        // sw x2,8(x1)
        applyStimulus(32'h0020A423, 32'h24, 32'h300, 32'hDEADBEEF);
        checkOutput("sw_addr",      ex_bus.ex_result,              32'h308);
        checkOutput("sw_data",      ex_bus.ex_store_data,          32'hDEADBEEF);
        checkOutput("sw_mem_write", {31'd0, ex_bus.ex_mem_write},  32'd1);
        checkOutput("sw_reg_write", {31'd0, ex_bus.ex_reg_write},  32'd0);

        // shifts and compares
        applyStimulus(32'h4020D1B3, 32'h28, 32'h80000000, 32'd4);
        checkOutput("sra_result", ex_bus.ex_result, 32'hF8000000);
        applyStimulus(32'h0020D1B3, 32'h2C, 32'h80000000, 32'd4);
        checkOutput("srl_result", ex_bus.ex_result, 32'h08000000);
        applyStimulus(32'h4040D193, 32'h30, 32'h80000000, 32'd0);
        checkOutput("srai_result", ex_bus.ex_result, 32'hF8000000);
        applyStimulus(32'h0020A1B3, 32'h34, 32'hFFFFFFFF, 32'd1);
        checkOutput("slt_result", ex_bus.ex_result, 32'd1);
        applyStimulus(32'h0020B1B3, 32'h38, 32'hFFFFFFFF, 32'd1);
        checkOutput("sltu_result", ex_bus.ex_result, 32'd0);
        applyStimulus(32'hFFF0C193, 32'h3C, 32'h0F0F0F0F, 32'd0);
        checkOutput("xori_result", ex_bus.ex_result, 32'hF0F0F0F0);

        // unknown opcode
        id_instr = 32'hFFFFFFFF;
        #1;
        checkOutput("illegal_imm", id_imm,          32'd0);
        checkOutput("illegal_jal", {31'd0, id_jal}, 32'd0);
        applyStimulus(32'hFFFFFFFF, 32'h44, 32'd5, 32'd6);
        checkOutput("illegal_reg_write", {31'd0, ex_bus.ex_reg_write}, 32'd0);
        checkOutput("illegal_result",    ex_bus.ex_result,             32'd0);

        // asynchronous reset in the middle of a cycle
        applyStimulus(32'h00500093, 32'h0, 32'd0, 32'd0);
        checkOutput("pre_reset_result", ex_bus.ex_result, 32'd5);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("async_rst_reg_write", {31'd0, ex_bus.ex_reg_write}, 32'd0);
        checkOutput("async_rst_result",    ex_bus.ex_result,             32'd0);
        reset = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vector_count, miscompare_count);
        $finish;
    end

endmodule
